// File: rtl/pgm_ddram_arbiter_pkg.sv
// Shared constants and types for the PGM DDRAM read-port arbiter.
package pgm_ddram_arbiter_pkg;

    localparam int DDR_AW = 29;
    localparam int DDR_DW = 64;
    localparam int DDR_BW = 8;

    localparam int REQ_SPR_A = 0;
    localparam int REQ_SPR_B = 1;
    localparam int REQ_TILE  = 2;
    localparam int NUM_REQ   = REQ_TILE + 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_DATA
    } arb_state_t;

    // A zero-length burst request is served as a single beat.
    function automatic logic [DDR_BW-1:0] burst_fix(input logic [DDR_BW-1:0] b);
        return (b == '0) ? DDR_BW'(1) : b;
    endfunction

endpackage

// File: rtl/pgm_ddram_arbiter_if.sv
// Requester and DDRAM bus bundle around the arbiter.
// master: fetch engines plus the DDRAM bridge (the arbiter's environment).
// slave:  the arbiter itself.
interface pgm_ddram_arbiter_if
    import pgm_ddram_arbiter_pkg::*;
#(
    parameter int NREQ = NUM_REQ
) ();

    logic                     urgent;
    logic [NREQ-1:0]          req;
    logic [NREQ*DDR_AW-1:0]   req_addr;
    logic [NREQ*DDR_BW-1:0]   req_burst;
    logic [NREQ-1:0]          ack;
    logic [DDR_DW-1:0]        rdata;
    logic [NREQ-1:0]          rvalid;
    logic [NREQ-1:0]          done;

    logic                     ddram_rd;
    logic [DDR_AW-1:0]        ddram_addr;
    logic [DDR_BW-1:0]        ddram_burstcnt;
    logic                     ddram_busy;
    logic [DDR_DW-1:0]        ddram_dout;
    logic                     ddram_dout_ready;

    modport master (
        output urgent, req, req_addr, req_burst,
        output ddram_busy, ddram_dout, ddram_dout_ready,
        input  ack, rdata, rvalid, done,
        input  ddram_rd, ddram_addr, ddram_burstcnt
    );

    modport slave (
        input  urgent, req, req_addr, req_burst,
        input  ddram_busy, ddram_dout, ddram_dout_ready,
        output ack, rdata, rvalid, done,
        output ddram_rd, ddram_addr, ddram_burstcnt
    );

endinterface

// File: rtl/pgm_ddram_arbiter_rr_pick.sv
// Combinational requester picker: strict lowest-index priority over the
// masked set when enabled, otherwise round-robin starting at ptr_i.
module pgm_rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] prio_mask_i,
    input  logic            prio_en_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IW-1:0]   gnt_idx_o
);

    logic [NREQ-1:0] prio_req;
    logic [NREQ-1:0] rot;
    logic [IW:0]     sum;

    assign prio_req = req_i & prio_mask_i;
    // rot[k] is the request at position ptr_i + k (mod NREQ)
    assign rot      = NREQ'({req_i, req_i} >> ptr_i);

    // Pick the winner; descending loops let the lowest index / nearest slot win.
    always_comb begin
        valid_o   = |req_i;
        gnt_idx_o = '0;
        sum       = '0;
        if (prio_en_i && (|prio_req)) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (prio_req[i]) begin
                    gnt_idx_o = IW'(i);
                end
            end
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (rot[k]) begin
                    sum = {1'b0, ptr_i} + (IW+1)'(k);
                end
            end
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            gnt_idx_o = sum[IW-1:0];
        end
        gnt_oh_o = valid_o ? (NREQ'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/pgm_ddram_arbiter.sv
// Shares the DDRAM read port between the sprite A, sprite B and tile fetchers.
// One burst outstanding at a time; returned beats are routed to the owner.
//
//  state     | meaning
//  ARB_IDLE  | no burst in flight; picks a winner when any req is set
//  ARB_ISSUE | ddram_rd asserted with latched addr/burst until busy drops
//  ARB_DATA  | counting returned beats, forwarding them to the owner
module pgm_ddram_arbiter
    import pgm_ddram_arbiter_pkg::*;
#(
    parameter int              NREQ     = NUM_REQ,
    parameter logic [NREQ-1:0] URG_MASK = NREQ'((1 << REQ_SPR_A) | (1 << REQ_SPR_B))
) (
    input logic                 clk,
    input logic                 reset,
    pgm_ddram_arbiter_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   gnt_oh_q, gnt_oh_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              rd_q, rd_d;
    logic [DDR_AW-1:0] addr_q, addr_d;
    logic [DDR_BW-1:0] burstcnt_q, burstcnt_d;
    logic [DDR_BW-1:0] cnt_q, cnt_d;
    logic [DDR_DW-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [NREQ-1:0]   done_q, done_d;

    logic              pick_valid;
    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     rr_next;

    pgm_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i       (bus.req),
        .prio_mask_i (URG_MASK),
        .prio_en_i   (bus.urgent),
        .ptr_i       (rr_ptr_q),
        .valid_o     (pick_valid),
        .gnt_oh_o    (pick_oh),
        .gnt_idx_o   (pick_idx)
    );

    assign rr_next = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);

    // Next-state logic: grant latch, command handshake, beat counting.
    always_comb begin
        state_d    = state_q;
        gnt_oh_d   = gnt_oh_q;
        rr_ptr_d   = rr_ptr_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        burstcnt_d = burstcnt_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = '0;
        done_d     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_oh_d   = pick_oh;
                    rr_ptr_d   = rr_next;
                    addr_d     = bus.req_addr[pick_idx*DDR_AW +: DDR_AW];
                    burstcnt_d = burst_fix(bus.req_burst[pick_idx*DDR_BW +: DDR_BW]);
                    rd_d       = 1'b1;
                    state_d    = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // Stray beats here are ignored; only the waitrequest matters.
                if (!bus.ddram_busy) begin
                    rd_d    = 1'b0;
                    cnt_d   = burstcnt_q;
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (bus.ddram_dout_ready) begin
                    rdata_d  = bus.ddram_dout;
                    rvalid_d = gnt_oh_q;
                    cnt_d    = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        done_d  = gnt_oh_q;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and output registers; reset also aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            gnt_oh_q   <= '0;
            rr_ptr_q   <= '0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            burstcnt_q <= DDR_BW'(1);
            cnt_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_oh_q   <= gnt_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            burstcnt_q <= burstcnt_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
        end
    end

    // Ack marks the accept cycle itself (rd high, waitrequest low).
    assign bus.ack            = (state_q == ARB_ISSUE && !bus.ddram_busy) ? gnt_oh_q : '0;
    assign bus.ddram_rd       = rd_q;
    assign bus.ddram_addr     = addr_q;
    assign bus.ddram_burstcnt = burstcnt_q;
    assign bus.rdata          = rdata_q;
    assign bus.rvalid         = rvalid_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// Directed bench for the DDRAM read-port arbiter.
module tb_pgm_ddram_arbiter;
    import pgm_ddram_arbiter_pkg::*;

    typedef struct {
        logic [2:0] req;
        logic       urgent;
        logic [7:0] burst;
        int         busy_cyc;
        bit         drop_early;
        int         exp_gnt;
        logic [7:0] exp_bc;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [28:0] addr_tab [3];
    vec_t        vecs [13];

    pgm_ddram_arbiter_if #(.NREQ(3)) bus ();

    pgm_ddram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pat(input int vi, input int g, input int b);
        return {16'hC0DE, 16'(vi), 16'(g), 16'(b)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd"},       64'(bus.ddram_rd),       64'd0);
        check({tag, "_addr"},     64'(bus.ddram_addr),     64'd0);
        check({tag, "_burstcnt"}, 64'(bus.ddram_burstcnt), 64'd1);
        check({tag, "_ack"},      64'(bus.ack),            64'd0);
        check({tag, "_rvalid"},   64'(bus.rvalid),         64'd0);
        check({tag, "_done"},     64'(bus.done),           64'd0);
        check({tag, "_rdata"},    64'(bus.rdata),          64'd0);
    endtask

    // Returns at the negedge of the first cycle with ddram_rd high.
    task automatic wait_rd(input string tag, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 8 && !ok; t++) begin
            @(negedge clk);
            if (bus.ddram_rd) ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) check({tag, "_rd_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int         g;
        int         nb;
        logic [2:0] oh;
        bit         ok;
        string      tg;
        g  = v.exp_gnt;
        oh = 3'(1 << g);
        nb = (v.burst == 8'd0) ? 1 : int'(v.burst);
        tg = $sformatf("v%0d", vi);

        @(posedge clk); #1;
        bus.req              = v.req;
        bus.urgent           = v.urgent;
        bus.req_burst        = {3{v.burst}};
        bus.ddram_busy       = (v.busy_cyc > 0);
        bus.ddram_dout_ready = 1'b0;
        wait_rd(tg, ok);
        if (!ok) return;

        for (int k = 0; k < v.busy_cyc; k++) begin
            check({tg, "_stall_rd"},  64'(bus.ddram_rd),       64'd1);
            check({tg, "_stall_addr"},64'(bus.ddram_addr),     64'(addr_tab[g]));
            check({tg, "_stall_bc"},  64'(bus.ddram_burstcnt), 64'(v.exp_bc));
            check({tg, "_stall_ack"}, 64'(bus.ack),            64'd0);
            check({tg, "_stray_rv"},  64'(bus.rvalid),         64'd0);
            @(posedge clk); #1;
            bus.ddram_dout_ready = 1'b1;
            bus.ddram_dout       = 64'hDEAD_BEEF_0000_0000 | 64'(k);
            if (v.drop_early) bus.req = '0;
            if (k == v.busy_cyc - 1) begin
                bus.ddram_busy       = 1'b0;
                bus.ddram_dout_ready = 1'b0;
            end
            @(negedge clk);
        end

        check({tg, "_rd"},     64'(bus.ddram_rd),       64'd1);
        check({tg, "_addr"},   64'(bus.ddram_addr),     64'(addr_tab[g]));
        check({tg, "_bc"},     64'(bus.ddram_burstcnt), 64'(v.exp_bc));
        check({tg, "_ack"},    64'(bus.ack),            64'(oh));
        check({tg, "_pre_rv"}, 64'(bus.rvalid),         64'd0);

        @(posedge clk); #1;
        bus.req              = '0;
        bus.ddram_dout_ready = 1'b1;
        bus.ddram_dout       = pat(vi, g, 0);
        @(negedge clk);
        check({tg, "_rd_drop"},  64'(bus.ddram_rd), 64'd0);
        check({tg, "_ack_once"}, 64'(bus.ack),      64'd0);

        for (int b = 0; b < nb; b++) begin
            @(posedge clk); #1;
            if (b + 1 < nb) bus.ddram_dout = pat(vi, g, b + 1);
            else            bus.ddram_dout_ready = 1'b0;
            @(negedge clk);
            check({tg, "_rvalid"}, 64'(bus.rvalid), 64'(oh));
            check({tg, "_rdata"},  bus.rdata,       pat(vi, g, b));
            check({tg, "_done"},   64'(bus.done),   (b == nb - 1) ? 64'(oh) : 64'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check({tg, "_rv_after"}, 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        bit ok;
        checks   = 0;
        failures = 0;

        addr_tab[0] = 29'h0001000;
        addr_tab[1] = 29'h0002000;
        addr_tab[2] = 29'h0000100;

        //          req     urg   burst  busy drop gnt bc
        vecs[0]  = '{3'b100, 1'b0, 8'd4,   0, 1'b0, 2, 8'd4};
        vecs[1]  = '{3'b010, 1'b0, 8'd2,   5, 1'b1, 1, 8'd2};
        vecs[2]  = '{3'b101, 1'b1, 8'd1,   0, 1'b0, 0, 8'd1};
        vecs[3]  = '{3'b010, 1'b0, 8'd1,   0, 1'b0, 1, 8'd1};
        vecs[4]  = '{3'b101, 1'b0, 8'd1,   0, 1'b0, 2, 8'd1};
        vecs[5]  = '{3'b111, 1'b0, 8'd1,   0, 1'b0, 0, 8'd1};
        vecs[6]  = '{3'b111, 1'b0, 8'd1,   0, 1'b0, 1, 8'd1};
        vecs[7]  = '{3'b111, 1'b0, 8'd1,   0, 1'b0, 2, 8'd1};
        vecs[8]  = '{3'b111, 1'b0, 8'd1,   0, 1'b0, 0, 8'd1};
        vecs[9]  = '{3'b001, 1'b0, 8'd0,   0, 1'b0, 0, 8'd1};
        vecs[10] = '{3'b100, 1'b1, 8'd1,   1, 1'b0, 2, 8'd1};
        vecs[11] = '{3'b110, 1'b1, 8'd1,   0, 1'b0, 1, 8'd1};
        vecs[12] = '{3'b011, 1'b0, 8'd255, 0, 1'b0, 0, 8'd255};

        reset                = 1'b1;
        bus.urgent           = 1'b0;
        bus.req              = '0;
        bus.req_addr         = {addr_tab[2], addr_tab[1], addr_tab[0]};
        bus.req_burst        = '0;
        bus.ddram_busy       = 1'b0;
        bus.ddram_dout       = '0;
        bus.ddram_dout_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Reset in the middle of an 8-beat burst after two beats.
        @(posedge clk); #1;
        bus.req       = 3'b001;
        bus.urgent    = 1'b0;
        bus.req_burst = {3{8'd8}};
        bus.ddram_busy = 1'b0;
        wait_rd("mrst", ok);
        if (ok) begin
            check("mrst_ack", 64'(bus.ack), 64'd1);
            @(posedge clk); #1;
            bus.req              = '0;
            bus.ddram_dout_ready = 1'b1;
            bus.ddram_dout       = pat(99, 0, 0);
            @(negedge clk);
            @(posedge clk); #1;
            bus.ddram_dout = pat(99, 0, 1);
            @(negedge clk);
            check("mrst_beat0_rv", 64'(bus.rvalid), 64'd1);
            check("mrst_beat0_d",  bus.rdata,       pat(99, 0, 0));
            @(posedge clk); #1;
            reset          = 1'b1;
            bus.ddram_dout = pat(99, 0, 2);
            @(negedge clk);
            check("mrst_beat1_rv", 64'(bus.rvalid), 64'd1);
            check("mrst_beat1_d",  bus.rdata,       pat(99, 0, 1));
            @(posedge clk); #1;
            reset          = 1'b0;
            bus.ddram_dout = 64'h5555_AAAA_5555_AAAA;
            @(negedge clk);
            check_reset_vals("mrst");
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("mrst_discard_rv",   64'(bus.rvalid), 64'd0);
                check("mrst_discard_done", 64'(bus.done),   64'd0);
            end
            @(posedge clk); #1;
            bus.ddram_dout_ready = 1'b0;
        end
        run_vec('{3'b100, 1'b0, 8'd2, 0, 1'b0, 2, 8'd2}, 20);
        run_vec('{3'b011, 1'b0, 8'd1, 2, 1'b0, 0, 8'd1}, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
